// File: rtl/rule_scan_ctrl_if.sv
// Bundle of every signal the rule-scan controller exchanges with the parser, rule RAM,
// DL compare block and forwarding stage. The master side is the controller.
interface rule_scan_ctrl_if;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [8:0] rule_count;
  logic [7:0] addr1;
  logic [7:0] addr2;
  logic       ram_rd;
  logic       act1;
  logic       act2;
  logic       dl_ena;
  logic       dl_ready;
  logic       dl_match1;
  logic       dl_match2;
  logic       verdict_valid;
  logic       verdict_ready;
  logic       verdict_accept;
  logic       verdict_hit;
  logic [7:0] verdict_rule;
  logic       timeout_err;

  modport master (
    input  pkt_valid, rule_count, act1, act2, dl_ready, dl_match1, dl_match2, verdict_ready,
    output pkt_ready, addr1, addr2, ram_rd, dl_ena, verdict_valid, verdict_accept,
           verdict_hit, verdict_rule, timeout_err
  );

  modport slave (
    output pkt_valid, rule_count, act1, act2, dl_ready, dl_match1, dl_match2, verdict_ready,
    input  pkt_ready, addr1, addr2, ram_rd, dl_ena, verdict_valid, verdict_accept,
           verdict_hit, verdict_rule, timeout_err
  );
endinterface

// File: rtl/rule_scan_ctrl.sv
// Rule scan sequencer: walks the rule table two rules at a time, starts the DL compare
// for each pair and returns a first-match verdict (rule A of a pair wins over rule B).
// Every output is a flop; next values are computed in one combinational block.
module rule_scan_ctrl #(
  parameter bit          DEFAULT_ACCEPT = 1'b0,
  parameter int unsigned TIMEOUT        = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  rule_scan_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Value the timeout counter holds on the last permitted WAIT cycle.
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [8:0] base_q, base_d;
  logic [8:0] count_q, count_d;
  logic [3:0] to_cnt_q, to_cnt_d;
  logic       v2_q, v2_d;
  logic       act1_q, act1_d;
  logic       act2_q, act2_d;

  logic       pkt_ready_q, pkt_ready_d;
  logic [7:0] addr1_q, addr1_d;
  logic [7:0] addr2_q, addr2_d;
  logic       ram_rd_q, ram_rd_d;
  logic       dl_ena_q, dl_ena_d;
  logic       verdict_valid_q, verdict_valid_d;
  logic       verdict_accept_q, verdict_accept_d;
  logic       verdict_hit_q, verdict_hit_d;
  logic [7:0] verdict_rule_q, verdict_rule_d;
  logic       timeout_err_q, timeout_err_d;

  // Counts above the table size are clamped so the scan never runs past rule 255.
  logic [8:0] count_clamp_s;
  logic [9:0] base_p1_s;
  logic [9:0] base_p2_s;
  logic [9:0] count_ext_s;

  assign count_clamp_s = (bus.rule_count > 9'd256) ? 9'd256 : bus.rule_count;
  assign base_p1_s     = {1'b0, base_q} + 10'd1;
  assign base_p2_s     = {1'b0, base_q} + 10'd2;
  assign count_ext_s   = {1'b0, count_q};

  assign bus.pkt_ready      = pkt_ready_q;
  assign bus.addr1          = addr1_q;
  assign bus.addr2          = addr2_q;
  assign bus.ram_rd         = ram_rd_q;
  assign bus.dl_ena         = dl_ena_q;
  assign bus.verdict_valid  = verdict_valid_q;
  assign bus.verdict_accept = verdict_accept_q;
  assign bus.verdict_hit    = verdict_hit_q;
  assign bus.verdict_rule   = verdict_rule_q;
  assign bus.timeout_err    = timeout_err_q;

  // Next-state and next-output logic for the scan sequence.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    count_d          = count_q;
    to_cnt_d         = to_cnt_q;
    v2_d             = v2_q;
    act1_d           = act1_q;
    act2_d           = act2_q;
    verdict_valid_d  = verdict_valid_q;
    verdict_accept_d = verdict_accept_q;
    verdict_hit_d    = verdict_hit_q;
    verdict_rule_d   = verdict_rule_q;
    timeout_err_d    = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.pkt_valid) begin
          count_d = count_clamp_s;
          base_d  = 9'd0;
          if (count_clamp_s == 9'd0) begin
            // Empty table: straight to the default policy, no RAM or DL traffic.
            state_d          = S_DONE;
            verdict_valid_d  = 1'b1;
            verdict_accept_d = DEFAULT_ACCEPT;
            verdict_hit_d    = 1'b0;
            verdict_rule_d   = 8'd0;
            timeout_err_d    = 1'b0;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        // Rule B exists only if it lies inside the configured count (odd count tail).
        v2_d    = (base_p1_s < count_ext_s);
        state_d = S_LOAD;
      end

      S_LOAD: begin
        act1_d   = bus.act1;
        act2_d   = bus.act2;
        to_cnt_d = 4'd0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (bus.dl_ready) begin
          if (bus.dl_match1) begin
            state_d          = S_DONE;
            verdict_valid_d  = 1'b1;
            verdict_accept_d = act1_q;
            verdict_hit_d    = 1'b1;
            verdict_rule_d   = base_q[7:0];
            timeout_err_d    = 1'b0;
          end else if (v2_q && bus.dl_match2) begin
            state_d          = S_DONE;
            verdict_valid_d  = 1'b1;
            verdict_accept_d = act2_q;
            verdict_hit_d    = 1'b1;
            verdict_rule_d   = base_p1_s[7:0];
            timeout_err_d    = 1'b0;
          end else begin
            base_d = base_p2_s[8:0];
            if (base_p2_s >= count_ext_s) begin
              state_d          = S_DONE;
              verdict_valid_d  = 1'b1;
              verdict_accept_d = DEFAULT_ACCEPT;
              verdict_hit_d    = 1'b0;
              verdict_rule_d   = 8'd0;
              timeout_err_d    = 1'b0;
            end else begin
              state_d = S_FETCH;
            end
          end
        end else begin
          if (to_cnt_q == TO_LAST) begin
            // DL never answered: fail safe by dropping the packet.
            state_d          = S_DONE;
            verdict_valid_d  = 1'b1;
            verdict_accept_d = 1'b0;
            verdict_hit_d    = 1'b0;
            verdict_rule_d   = 8'd0;
            timeout_err_d    = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 4'd1;
          end
        end
      end

      S_DONE: begin
        if (bus.verdict_ready) begin
          verdict_valid_d = 1'b0;
          timeout_err_d   = 1'b0;
          base_d          = 9'd0;
          state_d         = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes and addresses follow the state being entered so they are registered.
    pkt_ready_d = (state_d == S_IDLE);
    ram_rd_d    = (state_d == S_FETCH);
    dl_ena_d    = (state_d == S_LOAD);
    if (state_d == S_FETCH) begin
      addr1_d = base_d[7:0];
      addr2_d = base_d[7:0] + 8'd1;
    end else begin
      addr1_d = addr1_q;
      addr2_d = addr2_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      base_q           <= 9'd0;
      count_q          <= 9'd0;
      to_cnt_q         <= 4'd0;
      v2_q             <= 1'b0;
      act1_q           <= 1'b0;
      act2_q           <= 1'b0;
      pkt_ready_q      <= 1'b1;
      addr1_q          <= 8'd0;
      addr2_q          <= 8'd0;
      ram_rd_q         <= 1'b0;
      dl_ena_q         <= 1'b0;
      verdict_valid_q  <= 1'b0;
      verdict_accept_q <= 1'b0;
      verdict_hit_q    <= 1'b0;
      verdict_rule_q   <= 8'd0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      count_q          <= count_d;
      to_cnt_q         <= to_cnt_d;
      v2_q             <= v2_d;
      act1_q           <= act1_d;
      act2_q           <= act2_d;
      pkt_ready_q      <= pkt_ready_d;
      addr1_q          <= addr1_d;
      addr2_q          <= addr2_d;
      ram_rd_q         <= ram_rd_d;
      dl_ena_q         <= dl_ena_d;
      verdict_valid_q  <= verdict_valid_d;
      verdict_accept_q <= verdict_accept_d;
      verdict_hit_q    <= verdict_hit_d;
      verdict_rule_q   <= verdict_rule_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_rule_scan_ctrl.sv
// Directed bench for rule_scan_ctrl with a behavioural rule RAM and DL responder.
module tb_rule_scan_ctrl;

  logic clk;
  logic rst_n;
  logic dl_resp_en;

  int n_checks;
  int n_fail;
  int n_rd;
  int n_ena;
  logic [15:0] last_pair;
  logic [15:0] prev_pair;

  logic match_tbl [0:255];
  logic act_tbl   [0:255];

  rule_scan_ctrl_if bus ();

  rule_scan_ctrl #(
    .DEFAULT_ACCEPT (1'b1),
    .TIMEOUT        (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rule RAM and DL model: data one cycle after ram_rd, DL answers one cycle after dl_ena.
  always @(posedge clk) begin
    if (bus.ram_rd) begin
      bus.act1  <= act_tbl[bus.addr1];
      bus.act2  <= act_tbl[bus.addr2];
      n_rd      <= n_rd + 1;
      prev_pair <= last_pair;
      last_pair <= {bus.addr1, bus.addr2};
    end
    if (bus.dl_ena) begin
      n_ena <= n_ena + 1;
    end
    bus.dl_ready  <= bus.dl_ena & dl_resp_en;
    bus.dl_match1 <= bus.dl_ena ? match_tbl[bus.addr1] : 1'b0;
    bus.dl_match2 <= bus.dl_ena ? match_tbl[bus.addr2] : 1'b0;
  end

  // Global time bound.
  initial begin
    #400000;
    $display("FAIL watchdog: obs=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 256; i++) begin
      match_tbl[i] = 1'b0;
      act_tbl[i]   = 1'b0;
    end
  endtask

  task automatic accept_pkt(input logic [8:0] cnt);
    @(negedge clk);
    bus.rule_count = cnt;
    bus.pkt_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.pkt_valid = 1'b0;
  endtask

  // Returns latency counted from the accept cycle (accept cycle = 0).
  task automatic wait_verdict(input string tag, output int lat);
    int cyc;
    cyc = 0;
    while (bus.verdict_valid !== 1'b1 && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_valid"}, 32'(bus.verdict_valid), 32'd1);
    lat = cyc + 1;
  endtask

  task automatic take_verdict(input string tag);
    @(negedge clk);
    bus.verdict_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.verdict_ready = 1'b0;
    chk({tag, "_vv_clr"}, 32'(bus.verdict_valid), 32'd0);
    chk({tag, "_pkt_rdy"}, 32'(bus.pkt_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int rd0;
    int ena0;
    n_checks = 0;
    n_fail   = 0;
    n_rd     = 0;
    n_ena    = 0;
    last_pair = 16'd0;
    prev_pair = 16'd0;
    dl_resp_en = 1'b1;
    rst_n = 1'b0;
    bus.pkt_valid = 1'b0;
    bus.rule_count = 9'd0;
    bus.verdict_ready = 1'b0;
    bus.act1 = 1'b0;
    bus.act2 = 1'b0;
    bus.dl_ready = 1'b0;
    bus.dl_match1 = 1'b0;
    bus.dl_match2 = 1'b0;
    clear_tables();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pkt_ready", 32'(bus.pkt_ready), 32'd1);
    chk("rst_ram_rd", 32'(bus.ram_rd), 32'd0);
    chk("rst_dl_ena", 32'(bus.dl_ena), 32'd0);
    chk("rst_vvalid", 32'(bus.verdict_valid), 32'd0);
    chk("rst_addrs", {16'd0, bus.addr1, bus.addr2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 4 rules, only rule 2 matches with action accept.
    match_tbl[2] = 1'b1;
    act_tbl[2]   = 1'b1;
    rd0 = n_rd;
    accept_pkt(9'd4);
    chk("t1_pkt_ready_low", 32'(bus.pkt_ready), 32'd0);
    wait_verdict("t1", lat);
    chk("t1_latency", 32'(lat), 32'd7);
    chk("t1_rd_pulses", 32'(n_rd - rd0), 32'd2);
    chk("t1_pair0", {16'd0, prev_pair}, {16'd0, 8'd0, 8'd1});
    chk("t1_pair1", {16'd0, last_pair}, {16'd0, 8'd2, 8'd3});
    chk("t1_verdict", {29'd0, bus.verdict_accept, bus.verdict_hit, bus.timeout_err}, 32'b110);
    chk("t1_rule", 32'(bus.verdict_rule), 32'd2);
    take_verdict("t1");

    // 3 rules, DL flags rule B of the second pair (rule 3, outside the table).
    clear_tables();
    match_tbl[3] = 1'b1;
    act_tbl[3]   = 1'b0;
    accept_pkt(9'd3);
    wait_verdict("t2", lat);
    chk("t2_latency", 32'(lat), 32'd7);
    chk("t2_verdict", {29'd0, bus.verdict_accept, bus.verdict_hit, bus.timeout_err}, 32'b100);
    chk("t2_rule", 32'(bus.verdict_rule), 32'd0);
    take_verdict("t2");

    // Empty table: verdict right after accept, no RAM or DL activity.
    clear_tables();
    rd0  = n_rd;
    ena0 = n_ena;
    accept_pkt(9'd0);
    wait_verdict("t3", lat);
    chk("t3_latency", 32'(lat), 32'd1);
    chk("t3_rd_pulses", 32'(n_rd - rd0), 32'd0);
    chk("t3_ena_pulses", 32'(n_ena - ena0), 32'd0);
    chk("t3_verdict", {29'd0, bus.verdict_accept, bus.verdict_hit, bus.timeout_err}, 32'b100);
    take_verdict("t3");

    // Both rules of pair (0,1) match: rule 0 wins and its drop action applies.
    clear_tables();
    match_tbl[0] = 1'b1;
    match_tbl[1] = 1'b1;
    act_tbl[0]   = 1'b0;
    act_tbl[1]   = 1'b1;
    accept_pkt(9'd2);
    wait_verdict("t4", lat);
    chk("t4_latency", 32'(lat), 32'd4);
    chk("t4_verdict", {29'd0, bus.verdict_accept, bus.verdict_hit, bus.timeout_err}, 32'b010);
    chk("t4_rule", 32'(bus.verdict_rule), 32'd0);
    take_verdict("t4");

    // Only rule B of the first pair matches.
    clear_tables();
    match_tbl[1] = 1'b1;
    act_tbl[1]   = 1'b1;
    accept_pkt(9'd4);
    wait_verdict("t5", lat);
    chk("t5_latency", 32'(lat), 32'd4);
    chk("t5_verdict", {29'd0, bus.verdict_accept, bus.verdict_hit, bus.timeout_err}, 32'b110);
    chk("t5_rule", 32'(bus.verdict_rule), 32'd1);
    take_verdict("t5");

    // DL never answers: timeout after 15 WAIT cycles, verdict held while not ready.
    clear_tables();
    match_tbl[0] = 1'b1;
    act_tbl[0]   = 1'b1;
    dl_resp_en = 1'b0;
    accept_pkt(9'd2);
    wait_verdict("t6", lat);
    chk("t6_latency", 32'(lat), 32'd18);
    chk("t6_verdict", {29'd0, bus.verdict_accept, bus.verdict_hit, bus.timeout_err}, 32'b001);
    chk("t6_rule", 32'(bus.verdict_rule), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t6_hold", {28'd0, bus.verdict_valid, bus.verdict_accept, bus.verdict_hit, bus.timeout_err},
          32'b1001);
    end
    take_verdict("t6");
    chk("t6_terr_clr", 32'(bus.timeout_err), 32'd0);
    dl_resp_en = 1'b1;

    // Full 256-rule table with no match.
    clear_tables();
    rd0  = n_rd;
    ena0 = n_ena;
    accept_pkt(9'd256);
    wait_verdict("t7", lat);
    chk("t7_latency", 32'(lat), 32'd385);
    chk("t7_ena_pulses", 32'(n_ena - ena0), 32'd128);
    chk("t7_rd_pulses", 32'(n_rd - rd0), 32'd128);
    chk("t7_last_pair", {16'd0, last_pair}, {16'd0, 8'd254, 8'd255});
    chk("t7_verdict", {29'd0, bus.verdict_accept, bus.verdict_hit, bus.timeout_err}, 32'b100);
    take_verdict("t7");

    // Count above 256 is clamped to the table size.
    ena0 = n_ena;
    accept_pkt(9'd511);
    wait_verdict("t8", lat);
    chk("t8_latency", 32'(lat), 32'd385);
    chk("t8_ena_pulses", 32'(n_ena - ena0), 32'd128);
    take_verdict("t8");

    // Reset in the middle of a long scan.
    accept_pkt(9'd256);
    repeat (40) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t9_pkt_ready", 32'(bus.pkt_ready), 32'd1);
    chk("t9_strobes", {30'd0, bus.ram_rd, bus.dl_ena}, 32'd0);
    chk("t9_addrs", {16'd0, bus.addr1, bus.addr2}, 32'd0);
    chk("t9_verdict", {27'd0, bus.verdict_valid, bus.verdict_accept, bus.verdict_hit,
                       bus.timeout_err, 1'b0}, 32'd0);
    chk("t9_rule", 32'(bus.verdict_rule), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Controller works normally after the reset.
    clear_tables();
    match_tbl[0] = 1'b1;
    act_tbl[0]   = 1'b1;
    repeat (2) @(posedge clk);
    accept_pkt(9'd2);
    wait_verdict("t10", lat);
    chk("t10_latency", 32'(lat), 32'd4);
    chk("t10_verdict", {29'd0, bus.verdict_accept, bus.verdict_hit, bus.timeout_err}, 32'b110);
    chk("t10_rule", 32'(bus.verdict_rule), 32'd0);
    take_verdict("t10");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
